// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: computes a + b + cin one bit per clock over WIDTH cycles,
// using a single full-adder cell fed by operand shift registers and a carry flop.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] ps_shift;

  // Full-adder cell on the current operand LSBs and the registered carry.
  assign bit_s = sa_q[0] ^ sb_q[0] ^ cy_q;
  assign bit_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & cy_q) | (sb_q[0] & cy_q);

  // Written as shift-then-insert so WIDTH=1 needs no special-case slice.
  always_comb begin
    ps_shift            = ps_q >> 1;
    ps_shift[WIDTH-1]   = bit_s;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cy_d    = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        ps_d  = ps_shift;
        cy_d  = bit_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = ps_shift;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: a cycle-phase reference model for the
// WIDTH=8 instance plus directed literal checks on WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder_fsm;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;

  int checks = 0;
  int errors = 0;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1..W = bits being processed, W+1 = result cycle.
  int          ph = 0;
  int          cyc = 0;
  logic [W:0]  m_res = '0;
  logic [W-1:0] m_sum = '0;
  logic        m_cout = 1'b0;
  bit          chk_en = 1'b0;
  int          done_q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = 0; m_sum = '0; m_cout = 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        m_res = {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
        ph = 1;
      end
    end else if (ph <= W) begin
      if (ph == W) {m_cout, m_sum} = m_res;
      ph++;
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("done", 32'(done), 32'(ph == W + 1));
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     input logic [8:0] exp_lit, input string tag);
    int k, nb;
    @(negedge clk); a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk); start = 1'b0; k = 1; nb = 0;
    while (!done && k < 40) begin
      if (busy) nb++;
      @(negedge clk); k++;
    end
    if (busy) nb++;
    chk({tag, "_latency"}, 32'(k), 32'(W + 1));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(W + 1));
    chk({tag, "_result"}, 32'({cout, sum}), 32'(exp_lit));
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, n;
    logic [1:0] e1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'({cout, sum}), 32'd0);
    rst = 1'b0;

    op8(8'h3C, 8'h5A, 1'b1, 9'h097, "add_3c_5a");
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff");

    // starts during RUN and during DONE must be ignored
    @(negedge clk); a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ignore_result", 32'({cout, sum}), 32'h046);
    n = 0;
    repeat (15) begin @(negedge clk); if (done) n++; end
    chk("ignore_no_second_done", 32'(n), 32'd0);
    chk("ignore_sum_held", 32'(sum), 32'h46);

    // reset in the 4th RUN cycle
    @(negedge clk); a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_result", 32'({cout, sum}), 32'd0);
    op8(8'h01, 8'h01, 1'b0, 9'h002, "after_reset");

    // start held high with operands changing every cycle
    done_q.delete();
    @(negedge clk); start = 1'b1;
    repeat (34) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    k = 0;
    while (busy && k < 20) begin @(negedge clk); k++; end
    chk("b2b_drained", 32'(busy), 32'd0);
    chk("b2b_done_count_ge3", 32'(done_q.size() >= 3), 32'd1);
    for (int i = 1; i < 3 && i < done_q.size(); i++)
      chk("b2b_done_spacing", 32'(done_q[i] - done_q[i-1]), 32'd10);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); {a1, b1, cin1} = 3'(i); start1 = 1'b1;
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      @(negedge clk); start1 = 1'b0; k = 1;
      while (!done1 && k < 10) begin @(negedge clk); k++; end
      chk("w1_latency", 32'(k), 32'd2);
      chk("w1_result", 32'({cout1, sum1}), 32'(e1));
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
